// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - memory-side load/store responder with programmable wait states
//
// Purpose: accepts one CPU load/store at a time over a valid/ready handshake,
// services it from an internal RAM of 2**ADDR_W 32-bit words after LATENCY
// wait cycles, and returns a single-cycle response pulse.
//
// Ports:
//   clk         clock, rising edge
//   reset       asynchronous active-low reset (0 = in reset)
//   req_valid   request present; held by the requester until accepted
//   req_ready   high only in IDLE and out of reset
//   req_write   1 = store, 0 = load
//   req_size    00 byte, 01 half, 10 word, 11 illegal
//   req_addr    byte address; word index = req_addr[ADDR_W+1:2]
//   req_wdata   right-aligned store data
//   resp_valid  one-cycle response pulse
//   resp_rdata  right-aligned, zero-extended load data; 0 for stores/errors
//   resp_err    misaligned or illegal-size request, valid with resp_valid

module mem_responder #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t              state;
  logic [2:0]          wait_cnt;

  logic                lat_write;
  logic [1:0]          lat_size;
  logic [1:0]          lat_lane;
  logic [ADDR_W-1:0]   lat_idx;
  logic [31:0]         lat_wdata;

  logic [31:0]         mem [0:(1<<ADDR_W)-1];

  logic                accept;
  logic                enter_resp;
  logic                mem_we;

  logic                cur_write;
  logic [1:0]          cur_size;
  logic [1:0]          cur_lane;
  logic [ADDR_W-1:0]   cur_idx;
  logic [31:0]         cur_wdata;
  logic                cur_err;

  logic [3:0]          byte_en;
  logic [31:0]         bit_mask;
  logic [31:0]         wdata_rep;
  logic [31:0]         old_word;
  logic [31:0]         merged;
  logic [31:0]         shifted;
  logic [31:0]         load_data;

  // Address bits above the word index alias and are deliberately dropped.
  logic                unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

  // Gated by reset so the requester never sees ready while the block is held.
  assign req_ready = reset & (state == S_IDLE);
  assign accept    = req_valid & req_ready;

  // With LATENCY=0 the response is scheduled on the accept edge itself,
  // before the latch holds the request, so the live inputs are used then.
  assign enter_resp = (accept & (LATENCY == 0)) |
                      ((state == S_WAIT) & (wait_cnt == 3'd1));
  assign mem_we     = enter_resp & cur_write & ~cur_err;

  always_comb begin
    cur_write = lat_write;
    cur_size  = lat_size;
    cur_lane  = lat_lane;
    cur_idx   = lat_idx;
    cur_wdata = lat_wdata;
    if (state == S_IDLE) begin
      cur_write = req_write;
      cur_size  = req_size;
      cur_lane  = req_addr[1:0];
      cur_idx   = req_addr[ADDR_W+1:2];
      cur_wdata = req_wdata;
    end

    cur_err = (cur_size == 2'b11) ||
              ((cur_size == 2'b01) && cur_lane[0]) ||
              ((cur_size == 2'b10) && (cur_lane != 2'b00));

    // Store data is replicated across lanes; byte_en picks which land.
    byte_en   = 4'b0000;
    wdata_rep = cur_wdata;
    case (cur_size)
      2'b00: begin
        byte_en   = 4'b0001 << cur_lane;
        wdata_rep = {4{cur_wdata[7:0]}};
      end
      2'b01: begin
        byte_en   = cur_lane[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{cur_wdata[15:0]}};
      end
      2'b10:   byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
    bit_mask = {{8{byte_en[3]}}, {8{byte_en[2]}}, {8{byte_en[1]}}, {8{byte_en[0]}}};

    old_word = mem[cur_idx];
    merged   = (old_word & ~bit_mask) | (wdata_rep & bit_mask);

    shifted = old_word >> {cur_lane, 3'b000};
    case (cur_size)
      2'b00:   load_data = {24'h0, shifted[7:0]};
      2'b01:   load_data = {16'h0, shifted[15:0]};
      default: load_data = old_word;
    endcase
  end

  // RAM has no reset; contents survive reset assertion.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[cur_idx] <= merged;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      wait_cnt   <= 3'd0;
      lat_write  <= 1'b0;
      lat_size   <= 2'b00;
      lat_lane   <= 2'b00;
      lat_idx    <= '0;
      lat_wdata  <= 32'h0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;

      case (state)
        S_IDLE: begin
          if (accept) begin
            lat_write <= req_write;
            lat_size  <= req_size;
            lat_lane  <= req_addr[1:0];
            lat_idx   <= req_addr[ADDR_W+1:2];
            lat_wdata <= req_wdata;
            if (LATENCY == 0) begin
              state <= S_RESP;
            end else begin
              state    <= S_WAIT;
              wait_cnt <= 3'(LATENCY);
            end
          end
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt - 3'd1;
          if (wait_cnt == 3'd1) begin
            state <= S_RESP;
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      if (enter_resp) begin
        resp_valid <= 1'b1;
        resp_err   <= cur_err;
        resp_rdata <= (cur_err || cur_write) ? 32'h0 : load_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - randomized self-checking bench for mem_responder (LATENCY 0, 1, 3)

module tb_mem_responder;

  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid  [NI];
  logic        req_ready  [NI];
  logic        req_write  [NI];
  logic [1:0]  req_size   [NI];
  logic [31:0] req_addr   [NI];
  logic [31:0] req_wdata  [NI];
  logic        resp_valid [NI];
  logic [31:0] resp_rdata [NI];
  logic        resp_err   [NI];

  int cyc = 0;
  int n_checks = 0;
  int n_err = 0;

  // Byte-addressed reference memory: 256 words = 1024 bytes per instance.
  logic [7:0] mb [NI][1024];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mem_responder #(
      .ADDR_W (8),
      .LATENCY(g == 0 ? 0 : (g == 1 ? 1 : 3))
    ) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_write (req_write[g]),
      .req_size  (req_size[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .resp_valid(resp_valid[g]),
      .resp_rdata(resp_rdata[g]),
      .resp_err  (resp_err[g])
    );
  end

  function automatic int lat_of(input int i);
    return (i == 0) ? 0 : ((i == 1) ? 1 : 3);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input int i, input bit w, input logic [1:0] sz,
                                input logic [31:0] a, input logic [31:0] d,
                                output logic [31:0] rd, output bit er);
    int nb;
    int base;
    er = (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
    rd = 32'h0;
    if (!er) begin
      nb   = 1 << sz;
      base = int'(a % 1024);
      for (int k = 0; k < nb; k++) begin
        if (w) mb[i][base + k] = 8'((d >> (8 * k)) & 32'hff);
        else   rd = rd | (32'(mb[i][base + k]) << (8 * k));
      end
    end
  endfunction

  // Issue one request on instance i (called at a negedge) and check its response.
  task automatic xact(input int i, input bit w, input logic [1:0] sz, input logic [31:0] a,
                      input logic [31:0] d, input bit hold,
                      output logic [31:0] rd, output int acc);
    logic [31:0] exp_rd;
    bit          exp_er;
    int          n;
    bit          busy_bad;
    bit          quiet_bad;
    model(i, w, sz, a, d, exp_rd, exp_er);
    req_valid[i] = 1'b1;
    req_write[i] = w;
    req_size[i]  = sz;
    req_addr[i]  = a;
    req_wdata[i] = d;
    n = 0;
    while (!req_ready[i] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", 64'(n < 20), 64'd1);
    acc = cyc;
    rd  = 32'h0;
    if (n >= 20) begin
      req_valid[i] = 1'b0;
      return;
    end
    @(negedge clk);
    if (!hold) begin
      // Post-accept input changes must be ignored.
      req_valid[i] = 1'b0;
      req_write[i] = 1'($urandom);
      req_size[i]  = 2'($urandom);
      req_addr[i]  = $urandom;
      req_wdata[i] = $urandom;
    end
    n = 1;
    busy_bad  = 1'b0;
    quiet_bad = 1'b0;
    while (!resp_valid[i] && n < 20) begin
      if (req_ready[i]) busy_bad = 1'b1;
      if (resp_rdata[i] != 32'h0 || resp_err[i]) quiet_bad = 1'b1;
      @(negedge clk);
      n++;
    end
    check("latency", 64'(n), 64'(lat_of(i) + 1));
    check("ready_busy", 64'(busy_bad | req_ready[i]), 64'd0);
    check("quiet_idle", 64'(quiet_bad), 64'd0);
    check("rdata", 64'(resp_rdata[i]), 64'(exp_rd));
    check("err", 64'(resp_err[i]), 64'(exp_er));
    rd = resp_rdata[i];
    if (!hold) begin
      @(negedge clk);
      check("pulse", {61'd0, resp_valid[i], resp_rdata[i] != 32'h0, resp_err[i]}, 64'd0);
    end
  endtask

  task automatic check_held(input string tag);
    for (int i = 0; i < NI; i++) begin
      check(tag, {req_ready[i], resp_valid[i], resp_err[i], resp_rdata[i]}, 64'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] a;
    logic [1:0]  sz;
    int          acc;
    int          prev;
    int          r;

    reset = 1'b0;
    for (int i = 0; i < NI; i++) begin
      req_valid[i] = 1'b0;
      req_write[i] = 1'b0;
      req_size[i]  = 2'b00;
      req_addr[i]  = 32'h0;
      req_wdata[i] = 32'h0;
    end
    repeat (2) @(negedge clk);
    check_held("reset_outputs");
    reset = 1'b1;
    @(negedge clk);

    // Fill every word so the model knows the whole RAM.
    for (int i = 0; i < NI; i++) begin
      for (int wd = 0; wd < 256; wd++) begin
        xact(i, 1'b1, 2'd2, 32'(wd * 4), $urandom, 1'b0, rd, acc);
      end
    end

    // Reset in the middle of a store's WAIT phase: store must not commit.
    for (int i = 1; i < NI; i++) begin
      req_valid[i] = 1'b1;
      req_write[i] = 1'b1;
      req_size[i]  = 2'd2;
      req_addr[i]  = 32'h10;
      req_wdata[i] = 32'hDEADBEEF;
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_held("midwait_reset");
    @(negedge clk);
    for (int i = 1; i < NI; i++) req_valid[i] = 1'b0;
    check_held("midwait_reset_hold");
    reset = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) check("ready_after_release", 64'(req_ready[i]), 64'd1);
    @(negedge clk);
    for (int i = 1; i < NI; i++) xact(i, 1'b0, 2'd2, 32'h10, 32'h0, 1'b0, rd, acc);

    // Directed lane tests on the LATENCY=1 instance.
    xact(1, 1'b1, 2'd2, 32'h20, 32'h12345678, 1'b0, rd, acc);
    xact(1, 1'b0, 2'd2, 32'h20, 32'h0, 1'b0, rd, acc);
    check("word_load", 64'(rd), 64'h12345678);
    xact(1, 1'b1, 2'd0, 32'h21, 32'h000000AB, 1'b0, rd, acc);
    xact(1, 1'b1, 2'd1, 32'h22, 32'h0000CDEF, 1'b0, rd, acc);
    xact(1, 1'b0, 2'd2, 32'h20, 32'h0, 1'b0, rd, acc);
    check("lane_merge", 64'(rd), 64'hCDEFAB78);
    xact(1, 1'b0, 2'd0, 32'h23, 32'h0, 1'b0, rd, acc);
    check("byte_load", 64'(rd), 64'h000000CD);
    xact(1, 1'b0, 2'd1, 32'h22, 32'h0, 1'b0, rd, acc);
    check("half_load", 64'(rd), 64'h0000CDEF);
    xact(1, 1'b1, 2'd2, 32'h22, 32'hFFFFFFFF, 1'b0, rd, acc);
    check("misaligned_rdata", 64'(rd), 64'h0);
    xact(1, 1'b0, 2'd3, 32'h20, 32'h0, 1'b0, rd, acc);
    check("illegal_rdata", 64'(rd), 64'h0);
    xact(1, 1'b0, 2'd2, 32'h20, 32'h0, 1'b0, rd, acc);
    check("after_errors", 64'(rd), 64'hCDEFAB78);
    // Upper address bits alias onto the same word.
    xact(1, 1'b0, 2'd2, 32'hABCD_FC20, 32'h0, 1'b0, rd, acc);
    check("alias_load", 64'(rd), 64'hCDEFAB78);

    // Back-to-back with req_valid held high.
    for (int i = 0; i < NI; i += 2) begin
      prev = 0;
      for (int k = 0; k < 6; k++) begin
        xact(i, 1'($urandom), 2'd2, 32'($urandom_range(0, 255) * 4), $urandom, 1'b1, rd, acc);
        if (k > 0) check("b2b_spacing", 64'(acc - prev), 64'(lat_of(i) + 2));
        prev = acc;
      end
      req_valid[i] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("b2b_no_dup", 64'(resp_valid[i]), 64'd0);
    end

    // Random mixed traffic.
    for (int i = 0; i < NI; i++) begin
      for (int t = 0; t < 150; t++) begin
        r  = $urandom_range(0, 9);
        sz = (r == 0) ? 2'd3 : 2'(r % 3);
        a  = $urandom;
        if ($urandom_range(0, 3) != 0) a = a & ~(32'(1 << sz) - 32'd1);
        xact(i, 1'($urandom), sz, a, $urandom, 1'b0, rd, acc);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
